// File: rtl/pmp_spill_checker_if.sv
// pmp_spill_checker_if: upstream request and downstream beat signals of the PMP spill stage.
// The slave modport is the checker's view; the master modport is the surrounding fabric's view.
interface pmp_spill_checker_if #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  valid_i;
  logic                  ready_o;
  logic [PLEN-1:0]       addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [2:0]            access_type_i;
  logic [1:0]            priv_lvl_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [PLEN-1:0]       addr_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  allow_o;

  modport slave (
    input  valid_i, addr_i, data_i, access_type_i, priv_lvl_i, ready_i,
    output ready_o, valid_o, addr_o, data_o, allow_o
  );

  modport master (
    output valid_i, addr_i, data_i, access_type_i, priv_lvl_i, ready_i,
    input  ready_o, valid_o, addr_o, data_o, allow_o
  );
endinterface

// File: rtl/pmp_spill_checker.sv
// pmp_spill_checker: 16-entry RISC-V PMP check feeding a two-slot spill register (or bypass).
// Optional macro PMP_LOCK_EN: locked (L=1) entries also restrict M-mode accesses.
module pmp_spill_checker #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned PMP_LEN    = 54,
  parameter int unsigned NR_ENTRIES = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter bit          BYPASS     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  pmp_spill_checker_if.slave     bus,
  input  logic [16*PMP_LEN-1:0]  conf_addr_i,
  input  logic [16*8-1:0]        conf_i
);

  localparam int unsigned SLOT_W = PLEN + DATA_WIDTH + 1;

  typedef struct packed {
    logic [PLEN-1:0]       addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  allow;
  } slot_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // NAPOT: cur ^ (cur + 1) marks the trailing ones plus the next bit, i.e. the don't-care word bits.
  function automatic logic entry_match(input logic [1:0]         mode_s,
                                       input logic [PMP_LEN-1:0] word_s,
                                       input logic [PMP_LEN-1:0] prev_s,
                                       input logic [PMP_LEN-1:0] cur_s);
    logic [PMP_LEN-1:0] free_s;
    logic               hit_s;
    free_s = cur_s ^ (cur_s + {{(PMP_LEN-1){1'b0}}, 1'b1});
    case (mode_s)
      2'd1:    hit_s = (word_s >= prev_s) && (word_s < cur_s);
      2'd2:    hit_s = (word_s == cur_s);
      2'd3:    hit_s = ((word_s ^ cur_s) & ~free_s) == {PMP_LEN{1'b0}};
      default: hit_s = 1'b0;
    endcase
    return hit_s;
  endfunction

  logic [PMP_LEN-1:0]    word_s;
  logic [16*PMP_LEN-1:0] prev_all_s;
  logic [15:0]           hit_s;
  logic [31:0]           reserved_s;
  logic                  match_s;
  logic                  perm_s;
  logic                  lock_s;
  logic                  allow_s;
  logic                  unused_s;

  assign word_s     = bus.addr_i[PLEN-1:2];
  assign prev_all_s = {conf_addr_i[15*PMP_LEN-1:0], {PMP_LEN{1'b0}}};

  for (genvar g = 0; g < 16; g++) begin : g_entry
    assign hit_s[g] = (g < NR_ENTRIES) &&
                      entry_match(conf_i[g*8+3 +: 2], word_s,
                                  prev_all_s[g*PMP_LEN +: PMP_LEN],
                                  conf_addr_i[g*PMP_LEN +: PMP_LEN]);
    assign reserved_s[g*2 +: 2] = conf_i[g*8+5 +: 2];
  end

  // Walk downwards so the lowest-index hit is the one left standing.
  always_comb begin
    perm_s = 1'b0;
    lock_s = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      perm_s = hit_s[i] ? ((bus.access_type_i & ~conf_i[i*8 +: 3]) == 3'b000) : perm_s;
      lock_s = hit_s[i] ? conf_i[i*8+7] : lock_s;
    end
    match_s = |hit_s;
  end

  // Verdict: U/S needs a permitting match; M is free unless a locked entry matches.
  always_comb begin
    if (bus.priv_lvl_i == 2'd3) begin
`ifdef PMP_LOCK_EN
      allow_s = (match_s && lock_s) ? perm_s : 1'b1;
`else
      allow_s = 1'b1;
`endif
    end else if (NR_ENTRIES == 32'd0) begin
      allow_s = 1'b1;
    end else begin
      allow_s = match_s & perm_s;
    end
  end

  assign unused_s = ^{reserved_s, lock_s};

  if (BYPASS) begin : g_bypass
    assign bus.valid_o = bus.valid_i;
    assign bus.ready_o = bus.ready_i;
    assign bus.addr_o  = bus.addr_i;
    assign bus.data_o  = bus.data_i;
    assign bus.allow_o = allow_s;
  end else begin : g_spill
    state_e state_r;
    logic   valid_r;
    logic   ready_r;
    slot_t  a_r;
    slot_t  b_r;
    slot_t  in_s;
    logic   accept_s;
    logic   drain_s;

    assign in_s     = {bus.addr_i, bus.data_i, allow_s};
    assign accept_s = bus.valid_i & ready_r;
    assign drain_s  = valid_r & bus.ready_i;

    // Slot A drives the output; slot B absorbs the one beat accepted while A is stalled.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= ST_EMPTY;
        valid_r <= 1'b0;
        ready_r <= 1'b1;
        a_r     <= {SLOT_W{1'b0}};
        b_r     <= {SLOT_W{1'b0}};
      end else begin
        case (state_r)
          ST_EMPTY: begin
            if (accept_s) begin
              a_r     <= in_s;
              state_r <= ST_ONE;
              valid_r <= 1'b1;
            end
          end
          ST_ONE: begin
            if (accept_s && drain_s) begin
              a_r <= in_s;
            end else if (accept_s) begin
              b_r     <= in_s;
              state_r <= ST_TWO;
              ready_r <= 1'b0;
            end else if (drain_s) begin
              state_r <= ST_EMPTY;
              valid_r <= 1'b0;
            end
          end
          ST_TWO: begin
            if (drain_s) begin
              a_r     <= b_r;
              state_r <= ST_ONE;
              ready_r <= 1'b1;
            end
          end
          default: begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
          end
        endcase
      end
    end

    assign bus.valid_o = valid_r;
    assign bus.ready_o = ready_r;
    assign bus.addr_o  = a_r.addr;
    assign bus.data_o  = a_r.data;
    assign bus.allow_o = a_r.allow;
  end

endmodule

// File: tb/tb_pmp_spill_checker.sv
// tb_pmp_spill_checker: scoreboard bench with a range-based PMP reference model.
// Directed test-plan beats carry constant verdicts; random beats use the model.
module tb_pmp_spill_checker;
  localparam int PLEN    = 56;
  localparam int PMP_LEN = 54;
  localparam int DW      = 64;
`ifdef PMP_LOCK_EN
  localparam int LOCKED_M_EXP = 0;
`else
  localparam int LOCKED_M_EXP = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [16*PMP_LEN-1:0] conf_addr_v;
  logic [127:0]          conf_v;

  pmp_spill_checker_if #(.PLEN(PLEN), .DATA_WIDTH(DW)) bus ();

  pmp_spill_checker #(
    .PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(16), .DATA_WIDTH(DW), .BYPASS(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .conf_addr_i(conf_addr_v), .conf_i(conf_v)
  );

  typedef struct packed {
    logic [PLEN-1:0] addr;
    logic [DW-1:0]   data;
    logic            allow;
  } beat_t;

  beat_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          seq = 0;
  logic [63:0] last_data;
  bit          rand_ready = 1'b0;
  bit          ready_force = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: each entry becomes a byte range [lo, hi); first containing range decides.
  function automatic bit model_allow(input logic [PLEN-1:0] a, input logic [2:0] acc,
                                     input logic [1:0] pv);
    longint unsigned addr, lo, hi, size, cw;
    logic [53:0] ca;
    logic [7:0]  c;
    int          k;
    bit          matched, perm, locked;
    addr = 64'(a);
    matched = 1'b0; perm = 1'b0; locked = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!matched) begin
        ca = conf_addr_v[i*PMP_LEN +: PMP_LEN];
        c  = conf_v[i*8 +: 8];
        cw = 64'(ca) << 2;
        lo = 0; hi = 0;
        case (c[4:3])
          2'd1: begin
            if (i > 0) lo = 64'(conf_addr_v[(i-1)*PMP_LEN +: PMP_LEN]) << 2;
            hi = cw;
          end
          2'd2: begin lo = cw; hi = cw + 4; end
          2'd3: begin
            k = 0;
            while (k < 54 && ca[k]) k++;
            size = 64'd1 << (k + 3);
            lo = cw & ~(size - 1);
            hi = lo + size;
          end
          default: begin lo = 0; hi = 0; end
        endcase
        if (addr >= lo && addr < hi) begin
          matched = 1'b1;
          perm    = (acc & ~c[2:0]) == 3'b000;
          locked  = c[7];
        end
      end
    end
    if (pv == 2'd3) begin
`ifdef PMP_LOCK_EN
      return (matched && locked) ? perm : 1'b1;
`else
      return 1'b1;
`endif
    end
    return matched ? perm : 1'b0;
  endfunction

  task automatic set_entry(input int i, input logic [53:0] ca, input logic [7:0] cfg);
    conf_addr_v[i*PMP_LEN +: PMP_LEN] = ca;
    conf_v[i*8 +: 8] = cfg;
  endtask

  task automatic clear_cfg();
    conf_addr_v = '0;
    conf_v = '0;
  endtask

  // Called at posedge+1; holds valid until accepted, pushes the expected beat at acceptance.
  task automatic send(input logic [PLEN-1:0] a, input logic [2:0] acc, input logic [1:0] pv,
                      input int exp_allow);
    beat_t b;
    int    n;
    seq++;
    last_data = {32'hDA7A_0000, 32'(seq)};
    bus.addr_i = a; bus.data_i = last_data; bus.access_type_i = acc; bus.priv_lvl_i = pv;
    bus.valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 200) begin n++; @(negedge clk); end
    if (!bus.ready_o) begin
      checks++; errors++;
      $display("FAIL send_timeout: ready_o got 0, required 1");
    end else begin
      b.addr  = a;
      b.data  = last_data;
      b.allow = (exp_allow < 0) ? model_allow(a, acc, pv) : exp_allow[0];
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending beats got %0d, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Single writer of ready_i, applied 2 time units after each edge.
  initial begin
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk); #2;
      bus.ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor: pops and compares on every handshake; checks stability while stalled.
  initial begin
    beat_t e;
    beat_t held;
    bit    hold_v;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_v) begin
        check("stall_valid", 64'(bus.valid_o), 64'd1);
        check("stall_beat", 64'({bus.addr_o, bus.allow_o} != {held.addr, held.allow} ||
                                bus.data_o != held.data), 64'd0);
      end
      hold_v = 1'b0;
      if (!rst && bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_beat: got data %0h, required no beat", bus.data_o);
        end else begin
          e = exp_q.pop_front();
          check("out_addr", 64'(bus.addr_o), 64'(e.addr));
          check("out_data", bus.data_o, e.data);
          check("out_allow", 64'(bus.allow_o), 64'(e.allow));
        end
      end else if (!rst && bus.valid_o) begin
        held.addr = bus.addr_o; held.data = bus.data_o; held.allow = bus.allow_o;
        hold_v = 1'b1;
      end
    end
  end

  initial begin
    logic [63:0] d0, d1;
    logic [53:0] ca;
    logic [PLEN-1:0] ra;
    logic [2:0] acc;
    time t0;
    rst = 1'b1;
    bus.valid_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
    bus.access_type_i = 3'b000; bus.priv_lvl_i = 2'd0;
    clear_cfg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_o", 64'(bus.valid_o), 64'd0);
    check("rst_ready_o", 64'(bus.ready_o), 64'd1);
    check("rst_addr_o", 64'(bus.addr_o), 64'd0);
    check("rst_data_o", bus.data_o, 64'd0);
    check("rst_allow_o", 64'(bus.allow_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // NAPOT 4 KiB at 0x8000_0000, RW, S mode
    set_entry(0, 54'h2000_01FF, 8'h1B);
    send(56'h8000_0100, 3'b001, 2'd1, 1);
    send(56'h8000_0FF8, 3'b010, 2'd1, 1);
    send(56'h8000_0100, 3'b100, 2'd1, 0);
    send(56'h8000_1000, 3'b001, 2'd1, 0);
    // TOR [0, 0x1000) read-only, U mode
    clear_cfg(); set_entry(0, 54'h400, 8'h09);
    send(56'h0FFC, 3'b001, 2'd0, 1);
    send(56'h1000, 3'b001, 2'd0, 0);
    // Priority: NA4 without perms shadows the RW NAPOT
    clear_cfg(); set_entry(0, 54'h2000_0000, 8'h10); set_entry(1, 54'h2000_01FF, 8'h1B);
    send(56'h8000_0000, 3'b001, 2'd1, 0);
    send(56'h8000_0004, 3'b001, 2'd1, 1);
    // M mode against locked and unlocked entries
    clear_cfg(); set_entry(0, 54'h2000_01FF, 8'h98);
    send(56'h8000_0100, 3'b001, 2'd3, LOCKED_M_EXP);
    set_entry(0, 54'h2000_01FF, 8'h18);
    send(56'h8000_0100, 3'b001, 2'd3, 1);
    send(56'h8000_0100, 3'b000, 2'd1, 1);
    send(56'h8000_0100, 3'b001, 2'd2, 0);
    // All-ones NAPOT, empty TOR behind an OFF entry, unmatched U and M
    clear_cfg(); set_entry(0, {54{1'b1}}, 8'h19);
    send(56'hAB_CDEF_0123_4567, 3'b001, 2'd1, 1);
    clear_cfg(); set_entry(0, 54'h400, 8'h00); set_entry(1, 54'h300, 8'h09);
    send(56'h0C00, 3'b001, 2'd1, 0);
    clear_cfg();
    send(56'h0040, 3'b001, 2'd0, 0);
    send(56'h0040, 3'b100, 2'd3, 1);
    drain_wait();

    // Backpressure: two beats fill A and B, then drain back-to-back
    ready_force = 1'b0;
    set_entry(0, 54'h2000_01FF, 8'h1B);
    @(posedge clk); #1;
    send(56'h8000_0200, 3'b001, 2'd1, 1); d0 = last_data;
    send(56'h8000_0208, 3'b100, 2'd1, 0); d1 = last_data;
    @(negedge clk);
    check("bp_ready_o_low", 64'(bus.ready_o), 64'd0);
    check("bp_valid_o", 64'(bus.valid_o), 64'd1);
    @(posedge clk); #1;
    ready_force = 1'b1;
    @(negedge clk);
    check("bp_first_d0", bus.data_o, d0);
    check("bp_first_allow", 64'(bus.allow_o), 64'd1);
    @(negedge clk);
    check("bp_next_valid", 64'(bus.valid_o), 64'd1);
    check("bp_next_d1", bus.data_o, d1);
    check("bp_next_allow", 64'(bus.allow_o), 64'd0);
    @(posedge clk); #1;
    t0 = $time;
    for (int i = 0; i < 8; i++) send(56'h8000_0300 + 56'(i * 8), 3'b001, 2'd1, 1);
    check("stream_cycles", 64'(($time - t0) / 10), 64'd8);
    drain_wait();

    // Reset with two beats buffered discards both
    ready_force = 1'b0;
    @(posedge clk); #1;
    send(56'h8000_0400, 3'b001, 2'd1, 1);
    send(56'h8000_0408, 3'b001, 2'd1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_valid_o", 64'(bus.valid_o), 64'd0);
    check("mid_rst_ready_o", 64'(bus.ready_o), 64'd1);
    check("mid_rst_data_o", bus.data_o, 64'd0);
    check("mid_rst_addr_o", 64'(bus.addr_o), 64'd0);
    @(posedge clk); #1;
    ready_force = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Random config, random traffic, random backpressure
    rand_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 16; i++) begin
        ca = 54'($urandom_range(0, 255));
        if ($urandom_range(0, 15) == 0) ca = {54{1'b1}};
        set_entry(i, ca, 8'($urandom));
      end
      for (int j = 0; j < 10; j++) begin
        ra = 56'($urandom_range(0, 1100));
        if ($urandom_range(0, 7) == 0) ra = 56'({$urandom, $urandom});
        case ($urandom_range(0, 3))
          0: acc = 3'b000;
          1: acc = 3'b001;
          2: acc = 3'b010;
          default: acc = 3'b100;
        endcase
        send(ra, acc, 2'($urandom_range(0, 3)), -1);
        if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
      end
    end
    rand_ready = 1'b0;
    ready_force = 1'b1;
    drain_wait();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pmp_spill_checker.md
Name: pmp_spill_checker

Overview:
- Elastic ready/valid pipeline stage for IO-PMP datapaths.
- Combinationally checks each incoming transaction address against a 16-entry RISC-V PMP configuration.
- Buffers the payload together with the resulting allow flag in a two-slot spill register (or passes it straight through in bypass mode).
- Sits between an AXI slave-side request channel and the downstream master port; downstream logic turns allow=0 into SLVERR.

Parameters:
- PLEN, 56, physical address width in bits.
- PMP_LEN, 54, width of each PMP address register; holds addr[PLEN-1:2]; must equal PLEN-2.
- NR_ENTRIES, 16, number of active PMP entries (0..16).
- DATA_WIDTH, 64, width of the opaque payload carried alongside the address.
- BYPASS, 0, 1 = purely combinational pass-through with no storage.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_i  in  1  input transaction valid.
- ready_o  out  1  stage can accept an input.
- addr_i  in  PLEN  transaction address.
- data_i  in  DATA_WIDTH  payload.
- access_type_i  in  3  one-hot access type: bit0 read, bit1 write, bit2 execute.
- priv_lvl_i  in  2  privilege level: 0 U, 1 S, 3 M (2 treated as S).
- conf_addr_i  in  16*PMP_LEN  PMP address registers; entry i at [i*PMP_LEN +: PMP_LEN].
- conf_i  in  16*8  pmpcfg bytes: bit0 R, bit1 W, bit2 X, bits4:3 A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), bit7 L.
- valid_o  out  1  output valid.
- ready_i  in  1  downstream ready.
- addr_o  out  PLEN  buffered address.
- data_o  out  DATA_WIDTH  buffered payload.
- allow_o  out  1  PMP verdict captured with this beat.

Behaviour:
- PMP check is combinational on addr_i / access_type_i / priv_lvl_i / conf_*.
  - Entries NR_ENTRIES..15 are ignored.
- Entry match rules:
  - OFF never matches.
  - TOR matches when prev <= addr[PLEN-1:2] < conf_addr[i], where prev = conf_addr[i-1] (0 for entry 0). An empty range matches nothing.
  - NA4 matches when addr[PLEN-1:2] == conf_addr[i].
  - NAPOT: let k = number of trailing ones in conf_addr[i]. Region size is 2^(k+3) bytes. Matches when addr[PLEN-1:k+3] == conf_addr[i][PMP_LEN-1:k+1]. All-ones conf_addr matches everything.
- Priority: the lowest-index matching entry alone decides; higher entries are ignored.
- Permission: granted when every set bit of access_type_i has its R/W/X bit set. access_type_i = 0 is granted.
- U/S mode:
  - matching entry → permission result;
  - no match → deny;
  - NR_ENTRIES = 0 → allow.
- M mode:
  - matching entry with L=1 → permission result;
  - otherwise → allow.
- Spill register, BYPASS = 0:
  - Two slots A (output) and B (spill); each holds {addr, data, allow}.
  - valid_o = A full. ready_o = !B full, registered (no combinational path from ready_i).
  - Input accepted on valid_i & ready_o. Output consumed on valid_o & ready_i.
  - Empty: accepted beat goes to A; valid_o rises the next cycle (1-cycle latency).
  - A full, downstream not ready, new accept: beat goes to B; ready_o drops the next cycle.
  - A drained while B full: B moves to A, B empties.
  - Simultaneous accept and drain while A only is full: new beat replaces A; full throughput (one beat per cycle).
  - Order is strictly FIFO. Outputs are stable while valid_o & !ready_i.
- BYPASS = 1:
  - valid_o = valid_i, ready_o = ready_i.
  - addr_o, data_o and allow_o are combinational from the inputs. No state.
- Reset: A and B empty. valid_o = 0, ready_o = 1, addr_o / data_o / allow_o = 0. Effective on the next edge.
  - Reset mid-transfer discards buffered beats.
- Config changes affect only beats accepted afterwards; verdicts already buffered are not recomputed.

Optional Feature:
- Macro: PMP_LOCK_EN.
- Defined: L bit honoured exactly as above; locked entries restrict M mode.
- Not defined: L bit ignored, M mode always allowed; U/S rules unchanged.

Test Plan:
- NAPOT at 0x8000_0000, 4 KiB: entry0 conf_addr = 0x2000_01FF, cfg = 0x1B, S mode.
  - read 0x8000_0100 → allow_o = 1;
  - write 0x8000_0FF8 → 1;
  - execute 0x8000_0100 → 0;
  - read 0x8000_1000 → 0 (no match).
- TOR: entry0 conf_addr = 0x400, cfg = 0x09, U-mode read.
  - 0x0FFC → allow 1; 0x1000 → allow 0.
- Priority: entry0 NA4 at 0x8000_0000 with cfg = 0x10 (no perms); entry1 NAPOT covering it with RW.
  - S read 0x8000_0000 → 0; S read 0x8000_0004 → 1.
- M mode, entry0 NAPOT cfg = 0x98 (L, no perms), read inside the region:
  - with PMP_LOCK_EN → 0;
  - without PMP_LOCK_EN → 1;
  - unlocked entry → 1.
- Backpressure: ready_i = 0, push beats D0, D1.
  - ready_o = 0 after the second accept;
  - raise ready_i → D0 then D1 on consecutive cycles with their allow flags;
  - then streaming 1 beat/cycle.
- Assert rst while two beats are buffered → next cycle valid_o = 0, ready_o = 1, data_o = 0; no beats emerge.
